// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter interface: per-source result offers in, broadcast ports out.
// "slave" is the arbiter side, "master" is the producer/consumer side.
interface cdb_arbiter_if #(
    parameter int NUM_SRC   = 4,
    parameter int NUM_PORTS = 2,
    parameter int ROBEN_W   = 5,
    parameter int DATA_W    = 32
);
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC*ROBEN_W-1:0]   src_ROBEN;
    logic [NUM_SRC*DATA_W-1:0]    src_Write_Data;
    logic [NUM_SRC-1:0]           src_EXCEPTION;
    logic [NUM_SRC-1:0]           src_ready;
    logic [NUM_PORTS-1:0]         out_valid;
    logic [NUM_PORTS*ROBEN_W-1:0] out_ROBEN;
    logic [NUM_PORTS*DATA_W-1:0]  out_Write_Data;
    logic [NUM_PORTS-1:0]         out_EXCEPTION;

    modport slave (
        input  src_valid, src_ROBEN, src_Write_Data, src_EXCEPTION,
        output src_ready, out_valid, out_ROBEN, out_Write_Data, out_EXCEPTION
    );

    modport master (
        output src_valid, src_ROBEN, src_Write_Data, src_EXCEPTION,
        input  src_ready, out_valid, out_ROBEN, out_Write_Data, out_EXCEPTION
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per result producer, round-robin
// grant of up to NUM_PORTS slots per cycle onto registered broadcast ports.
// Optional macro CDB_BYPASS_EN: an empty, offering source may arbitrate in the
// same cycle and go straight to the port registers (zero-latency path).
module cdb_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int NUM_PORTS = 2,
    parameter int ROBEN_W   = 5,
    parameter int DATA_W    = 32
) (
    input logic          clk,
    input logic          rst,
    input logic          ROB_FLUSH_Flag,
    cdb_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0][ROBEN_W-1:0]   s_rob, h_rob;
    logic [NUM_SRC-1:0][DATA_W-1:0]    s_data, h_data;
    logic [NUM_SRC-1:0]                occ, h_exc, rob_nz, byp, cand, grant, ready, acc;
    logic [NUM_SRC-1:0]                cand_rot, grant_rot;
    logic [2*NUM_SRC-1:0]              cand_rot2, grant_rot2;
    logic [NUM_PORTS-1:0][PTR_W-1:0]   sel;
    logic [NUM_PORTS-1:0]              sel_vld;
    logic [PTR_W-1:0]                  last, rr_ptr;
    logic                              any_grant;
    logic [NUM_PORTS-1:0][ROBEN_W-1:0] p_rob, o_rob;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  p_data, o_data;
    logic [NUM_PORTS-1:0]              p_exc, o_exc, o_vld;

    assign s_rob  = bus.src_ROBEN;
    assign s_data = bus.src_Write_Data;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        // ROBEN 0 means "nothing to write back": handshake only, never stored
        assign rob_nz[i] = |s_rob[i];
`ifdef CDB_BYPASS_EN
        assign byp[i] = ~occ[i] & bus.src_valid[i] & rob_nz[i] & ~ROB_FLUSH_Flag & ~rst;
`else
        assign byp[i] = 1'b0;
`endif
    end

    assign cand = occ | byp;

    // Rotate candidates so bit 0 is the source at rr_ptr; scan then rotates back
    assign cand_rot2 = {cand, cand} >> rr_ptr;
    assign cand_rot  = cand_rot2[NUM_SRC-1:0];

    // Round-robin scan: k-th candidate found goes to port k
    always_comb begin
        int cnt;
        grant_rot = '0;
        sel       = '0;
        sel_vld   = '0;
        last      = '0;
        any_grant = 1'b0;
        cnt       = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (cand_rot[k] && cnt < NUM_PORTS) begin
                grant_rot[k] = 1'b1;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (p == cnt) begin
                        sel[p]     = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
                        sel_vld[p] = 1'b1;
                    end
                end
                last      = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
                any_grant = 1'b1;
                cnt       = cnt + 1;
            end
        end
    end

    assign grant_rot2 = {grant_rot, grant_rot} << rr_ptr;
    assign grant      = grant_rot2[2*NUM_SRC-1:NUM_SRC];

    // A slot frees up when empty or when it is being drained this cycle
    assign ready = (~occ | grant) & {NUM_SRC{~ROB_FLUSH_Flag & ~rst}};
    assign acc   = bus.src_valid & ready;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        // Occupied slot wins; an empty granted source can only be a bypass
        assign p_rob[p]  = occ[sel[p]] ? h_rob[sel[p]]  : s_rob[sel[p]];
        assign p_data[p] = occ[sel[p]] ? h_data[sel[p]] : s_data[sel[p]];
        assign p_exc[p]  = occ[sel[p]] ? h_exc[sel[p]]  : bus.src_EXCEPTION[sel[p]];
    end

    // Holding slots, broadcast registers and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            occ    <= '0;
            h_rob  <= '0;
            h_data <= '0;
            h_exc  <= '0;
            o_vld  <= '0;
            o_rob  <= '0;
            o_data <= '0;
            o_exc  <= '0;
            rr_ptr <= '0;
        end else if (ROB_FLUSH_Flag) begin
            occ    <= '0;
            o_vld  <= '0;
            o_rob  <= '0;
            o_data <= '0;
            o_exc  <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                o_vld[p]  <= sel_vld[p];
                o_rob[p]  <= sel_vld[p] ? p_rob[p]  : '0;
                o_data[p] <= sel_vld[p] ? p_data[p] : '0;
                o_exc[p]  <= sel_vld[p] & p_exc[p];
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (acc[i] && rob_nz[i] && !(grant[i] && !occ[i])) begin
                    occ[i]    <= 1'b1;
                    h_rob[i]  <= s_rob[i];
                    h_data[i] <= s_data[i];
                    h_exc[i]  <= bus.src_EXCEPTION[i];
                end else if (grant[i]) begin
                    occ[i] <= 1'b0;
                end
            end
            if (any_grant)
                rr_ptr <= (int'(last) == NUM_SRC - 1) ? '0 : last + 1'b1;
        end
    end

    assign bus.src_ready      = ready;
    assign bus.out_valid      = o_vld;
    assign bus.out_ROBEN      = o_rob;
    assign bus.out_Write_Data = o_data;
    assign bus.out_EXCEPTION  = o_exc;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_SRC=4, NUM_PORTS=2, default build).
module tb_cdb_arbiter;
    logic clk;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    logic [3:0][4:0]  s_rob;
    logic [3:0][31:0] s_data;
    logic [3:0]       s_vld, s_exc;
    logic [1:0][4:0]  orob;
    logic [1:0][31:0] odat;

    cdb_arbiter_if #(.NUM_SRC(4), .NUM_PORTS(2), .ROBEN_W(5), .DATA_W(32)) bus ();

    cdb_arbiter #(.NUM_SRC(4), .NUM_PORTS(2), .ROBEN_W(5), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ROB_FLUSH_Flag (flush),
        .bus            (bus)
    );

    assign bus.src_valid      = s_vld;
    assign bus.src_ROBEN      = s_rob;
    assign bus.src_Write_Data = s_data;
    assign bus.src_EXCEPTION  = s_exc;
    assign orob               = bus.out_ROBEN;
    assign odat               = bus.out_Write_Data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        s_vld  = '0;
        s_rob  = '0;
        s_data = '0;
        s_exc  = '0;
    endtask

    task automatic offer(input int s, input logic [4:0] r, input logic [31:0] d, input logic e);
        s_vld[s]  = 1'b1;
        s_rob[s]  = r;
        s_data[s] = d;
        s_exc[s]  = e;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        clr();
        #2;
        chk("rst_ready", bus.src_ready, 4'h0);
        step();
        chk("rst_vld", bus.out_valid, 2'b00);
        chk("rst_rob", bus.out_ROBEN, 10'h0);
        chk("rst_data", bus.out_Write_Data, 64'h0);
        chk("rst_exc", bus.out_EXCEPTION, 2'b00);
        chk("rst_rr", dut.rr_ptr, 2'd0);
        rst = 1'b0;

        // single offer from source 2, with exception flag
        offer(2, 5'd7, 32'hDEADBEEF, 1'b1);
        #1 chk("t1_ready", bus.src_ready, 4'hF);
        step();
        clr();
        chk("t1_e1_vld", bus.out_valid, 2'b00);
        step();
        chk("t1_vld", bus.out_valid, 2'b01);
        chk("t1_rob0", orob[0], 5'd7);
        chk("t1_dat0", odat[0], 32'hDEADBEEF);
        chk("t1_exc", bus.out_EXCEPTION, 2'b01);
        chk("t1_rob1", orob[1], 5'd0);
        chk("t1_rr", dut.rr_ptr, 2'd3);
        step();
        chk("t1_once", bus.out_valid, 2'b00);
        chk("t1_rob_clr", orob[0], 5'd0);

        // all four sources at once from rr_ptr=0
        do_reset();
        for (int i = 0; i < 4; i++) offer(i, 5'(i + 1), 32'h100 + i, 1'b0);
        step();
        clr();
        step();
        chk("t2_vld_a", bus.out_valid, 2'b11);
        chk("t2_rob0_a", orob[0], 5'd1);
        chk("t2_rob1_a", orob[1], 5'd2);
        chk("t2_dat1_a", odat[1], 32'h101);
        chk("t2_rr_a", dut.rr_ptr, 2'd2);
        step();
        chk("t2_rob0_b", orob[0], 5'd3);
        chk("t2_rob1_b", orob[1], 5'd4);
        chk("t2_rr_b", dut.rr_ptr, 2'd0);
        step();
        chk("t2_idle", bus.out_valid, 2'b00);

        // continuous contention on every source
        do_reset();
        for (int i = 0; i < 4; i++) offer(i, 5'(i + 1), 32'(i), 1'b0);
        #1 chk("t3_ready0", bus.src_ready, 4'hF);
        step();
        chk("t3_ready1", bus.src_ready, 4'b0011);
        step();
        chk("t3_rob_e2", {orob[1], orob[0]}, {5'd2, 5'd1});
        chk("t3_ready2", bus.src_ready, 4'b1100);
        step();
        chk("t3_rob_e3", {orob[1], orob[0]}, {5'd4, 5'd3});
        chk("t3_ready3", bus.src_ready, 4'b0011);
        step();
        chk("t3_rob_e4", {orob[1], orob[0]}, {5'd2, 5'd1});
        clr();
        step();
        chk("t3_rob_e5", {orob[1], orob[0]}, {5'd4, 5'd3});
        chk("t3_rr_e5", dut.rr_ptr, 2'd0);
        // reset while sources 0,1 still hold results and all are offering
        rst = 1'b1;
        for (int i = 0; i < 4; i++) offer(i, 5'(i + 1), 32'(i), 1'b0);
        #1 chk("t3_rst_ready", bus.src_ready, 4'h0);
        step();
        chk("t3_rst_vld", bus.out_valid, 2'b00);
        chk("t3_rst_rr", dut.rr_ptr, 2'd0);
        rst = 1'b0;
        clr();
        step();
        chk("t3_rst_drop", bus.out_valid, 2'b00);

        // flush with slots 1 and 3 occupied
        do_reset();
        offer(1, 5'd5, 32'h55, 1'b0);
        offer(3, 5'd6, 32'h66, 1'b0);
        step();
        clr();
        flush = 1'b1;
        #1 chk("t4_ready", bus.src_ready, 4'h0);
        step();
        flush = 1'b0;
        chk("t4_vld_a", bus.out_valid, 2'b00);
        step();
        chk("t4_vld_b", bus.out_valid, 2'b00);
        chk("t4_rr", dut.rr_ptr, 2'd0);

        // ROBEN 0 completes the handshake but is never broadcast
        do_reset();
        offer(1, 5'd0, 32'h1234, 1'b0);
        #1 chk("t5_ready", bus.src_ready[1], 1'b1);
        step();
        clr();
        step();
        chk("t5_vld_a", bus.out_valid, 2'b00);
        step();
        chk("t5_vld_b", bus.out_valid, 2'b00);
        chk("t5_rr", dut.rr_ptr, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
